// File: rtl/data_fsm_pkg.sv
// Shared types and default constants for the SD-card SPI acquisition controller.
package data_fsm_pkg;

  typedef enum logic [2:0] {IDLE, CMD, HUNT, VIDEO, AUDIO, WAIT_FRAME} state_t;

  localparam logic [7:0]  HEADER_DEF      = 8'hFF;
  localparam int          CMD_BITS_DEF    = 48;
  localparam logic [47:0] CMD_WORD_DEF    = 48'h52_0000_0000_FF;
  localparam int          HDR_TIMEOUT_DEF = 4096;

endpackage

// File: rtl/data_fsm_rx_shift.sv
// 8-bit MISO shifter gated by the bit strobe; flags when the incoming bit completes HEADER.
module data_fsm_rx_shift #(
  parameter logic [7:0] HEADER = 8'hFF
) (
  input  logic CLK_40,
  input  logic reset,
  input  logic en,
  input  logic clr,
  input  logic MISO,
  output logic match
);

  // Only the low 7 bits survive a shift, so the oldest bit is never stored.
  logic [6:0] rx;
  logic [7:0] rx_nxt;

  assign rx_nxt = {rx, MISO};
  assign match  = en && (rx_nxt == HEADER);

  always_ff @(posedge CLK_40 or negedge reset) begin
    if (!reset)   rx <= '0;
    else if (clr) rx <= '0;
    else if (en)  rx <= rx_nxt[6:0];
  end

endmodule

// File: rtl/data_fsm.sv
// SPI-mode-0 SD streaming controller: command out, header hunt, video/audio steering.
// Optional header-hunt timeout is enabled by defining DATA_FSM_TIMEOUT_EN.
module data_fsm
  import data_fsm_pkg::*;
#(
  parameter logic [7:0]          HEADER   = HEADER_DEF,
  parameter int                  CMD_BITS = CMD_BITS_DEF,
  parameter logic [CMD_BITS-1:0] CMD_WORD = CMD_BITS'(CMD_WORD_DEF)
`ifdef DATA_FSM_TIMEOUT_EN
  , parameter int                HDR_TIMEOUT = HDR_TIMEOUT_DEF
`endif
) (
  input  logic CLK_40,
  input  logic reset,
  input  logic SPI_clk_en,
  input  logic start,
  input  logic MISO,
  input  logic video_bank_full,
  input  logic audio_bank_full,
  input  logic frame_done,
  output logic MOSI,
  output logic chip_select,
  output logic write_video,
  output logic write_audio,
  output logic timeout
);

`ifdef DATA_FSM_TIMEOUT_EN
  localparam int CNT_MAX = (HDR_TIMEOUT > CMD_BITS) ? HDR_TIMEOUT : CMD_BITS;
`else
  localparam int CNT_MAX = CMD_BITS;
`endif
  localparam int CNT_W = $clog2(CNT_MAX);
  localparam logic [CMD_BITS-1:0] CMD_MSB = {1'b1, {(CMD_BITS-1){1'b0}}};

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             fd_lat, fd_n;
  logic             clr_rx, match, mosi_n;

  data_fsm_rx_shift #(.HEADER(HEADER)) u_rx (
    .CLK_40 (CLK_40),
    .reset  (reset),
    .en     (SPI_clk_en && (state == HUNT)),
    .clr    (clr_rx),
    .MISO   (MISO),
    .match  (match)
  );

  // Command bit for the count being entered, picked by a walking one so no index math.
  assign mosi_n = |(CMD_WORD & (CMD_MSB >> cnt_n));

`ifdef DATA_FSM_TIMEOUT_EN
  logic to_q, to_n;
  assign timeout = to_q;
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    fd_n    = fd_lat;
    clr_rx  = 1'b0;
`ifdef DATA_FSM_TIMEOUT_EN
    to_n    = to_q;
`endif
    case (state)
      IDLE: if (start) begin
        state_n = CMD;
        cnt_n   = '0;
      end
      CMD: if (SPI_clk_en) begin
        if (cnt == CNT_W'(CMD_BITS - 1)) begin
          state_n = HUNT;
          cnt_n   = '0;
          clr_rx  = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      HUNT: if (SPI_clk_en) begin
        if (match) state_n = VIDEO;
`ifdef DATA_FSM_TIMEOUT_EN
        else if (cnt == CNT_W'(HDR_TIMEOUT - 1)) begin
          state_n = IDLE;
          to_n    = 1'b1;
        end else cnt_n = cnt + 1'b1;
`endif
      end
      VIDEO: begin
        if (frame_done)      fd_n    = 1'b1;
        if (video_bank_full) state_n = AUDIO;
      end
      AUDIO: begin
        if (frame_done)      fd_n    = 1'b1;
        if (audio_bank_full) state_n = WAIT_FRAME;
      end
      WAIT_FRAME: if (frame_done || fd_lat) begin
        state_n = HUNT;
        fd_n    = 1'b0;
        cnt_n   = '0;
        clr_rx  = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are flopped from the next state so they change on the same edge as the state.
  always_ff @(posedge CLK_40 or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      fd_lat      <= 1'b0;
      chip_select <= 1'b1;
      MOSI        <= 1'b1;
      write_video <= 1'b0;
      write_audio <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      fd_lat      <= fd_n;
      chip_select <= (state_n == IDLE);
      MOSI        <= (state_n == CMD) ? mosi_n : 1'b1;
      write_video <= (state_n == VIDEO);
      write_audio <= (state_n == AUDIO);
    end
  end

`ifdef DATA_FSM_TIMEOUT_EN
  always_ff @(posedge CLK_40 or negedge reset) begin
    if (!reset) to_q <= 1'b0;
    else        to_q <= to_n;
  end
`endif

endmodule

// File: tb/tb_data_fsm.sv
`timescale 1ns/1ps
module tb_data_fsm;

  localparam int STROBE = 40;
  localparam logic [7:0] HDR = 8'hFF;
`ifdef DATA_FSM_TIMEOUT_EN
  localparam int   HDR_TO = 16;
  localparam logic TO_E   = 1'b1;
`else
  localparam int   HDR_TO = 0;
  localparam logic TO_E   = 1'b0;
`endif

  logic CLK_40 = 1'b0, reset = 1'b0, SPI_clk_en = 1'b0, start = 1'b0, MISO = 1'b0;
  logic video_bank_full = 1'b0, audio_bank_full = 1'b0, frame_done = 1'b0;
  logic MOSI, chip_select, write_video, write_audio, timeout;

  always #12.5 CLK_40 = ~CLK_40;

`ifdef DATA_FSM_TIMEOUT_EN
  data_fsm #(.HDR_TIMEOUT(HDR_TO)) dut (
    .CLK_40(CLK_40), .reset(reset), .SPI_clk_en(SPI_clk_en), .start(start), .MISO(MISO),
    .video_bank_full(video_bank_full), .audio_bank_full(audio_bank_full), .frame_done(frame_done),
    .MOSI(MOSI), .chip_select(chip_select), .write_video(write_video), .write_audio(write_audio),
    .timeout(timeout)
  );
`else
  data_fsm dut (
    .CLK_40(CLK_40), .reset(reset), .SPI_clk_en(SPI_clk_en), .start(start), .MISO(MISO),
    .video_bank_full(video_bank_full), .audio_bank_full(audio_bank_full), .frame_done(frame_done),
    .MOSI(MOSI), .chip_select(chip_select), .write_video(write_video), .write_audio(write_audio),
    .timeout(timeout)
  );
`endif

  int checks = 0, failures = 0;
  int tick = 0;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, exp);
      if (failures >= 40) begin
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s t=%0t got=timeout want=event", name, $time);
  endtask

  byte unsigned cmd_bytes [6] = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF};
  int  mph, cidx, hs;
  bit  fdp, mto;
  bit  hq[$];
  bit  mosi_seen[$];

  function automatic bit cmd_bit(input int i);
    byte unsigned b;
    b = cmd_bytes[i / 8];
    return b[7 - (i % 8)];
  endfunction

  function automatic bit hdr_hit();
    logic [7:0] v = '0;
    int s = hq.size();
    for (int i = (s > 8) ? s - 8 : 0; i < s; i++) v = {v[6:0], hq[i]};
    return v == HDR;
  endfunction

  task automatic model_reset();
    mph = 0; cidx = 0; hs = 0; fdp = 0; mto = 0;
    hq.delete();
    mosi_seen.delete();
  endtask

  task automatic model_step();
    if (!reset) begin
      model_reset();
      return;
    end
    case (mph)
      0: if (start) begin mph = 1; cidx = 0; mosi_seen.delete(); end
      1: if (SPI_clk_en) begin
        cidx++;
        if (cidx == 48) begin mph = 2; hq.delete(); hs = 0; end
      end
      2: if (SPI_clk_en) begin
        hq.push_back(MISO);
        if (hdr_hit()) mph = 3;
        else begin
          hs++;
          if (HDR_TO > 0 && hs == HDR_TO) begin mph = 0; mto = 1; end
        end
      end
      3: begin if (frame_done) fdp = 1; if (video_bank_full) mph = 4; end
      4: begin if (frame_done) fdp = 1; if (audio_bank_full) mph = 5; end
      default: if (frame_done || fdp) begin mph = 2; fdp = 0; hq.delete(); hs = 0; end
    endcase
  endtask

  function automatic logic [4:0] outs();
    return {chip_select, MOSI, write_video, write_audio, timeout};
  endfunction

  function automatic logic [4:0] exp_out();
    return {mph == 0, (mph == 1) ? cmd_bit(cidx) : 1'b1, mph == 3, mph == 4, mto};
  endfunction

  task automatic cyc();
    SPI_clk_en = (tick % STROBE == STROBE - 1);
    tick++;
    if (SPI_clk_en && mph == 1 && reset) mosi_seen.push_back(MOSI);
    model_step();
    @(posedge CLK_40); #1;
    check("cycle", outs(), exp_out());
  endtask

  task automatic wait_phase(input int ph, input int budget, input string name);
    int k = 0;
    while (mph != ph && k < budget) begin cyc(); k++; end
    if (mph != ph) bound_fail(name);
  endtask

  typedef struct {
    string      name;
    int         n;
    int         miso;
    logic       st, vbf, abf, fd;
    logic [4:0] exp;
  } seg_t;

  function automatic seg_t mk(input string nm, input int n, input int mi, input logic st,
                              input logic vbf, input logic abf, input logic fd, input logic [4:0] e);
    seg_t s;
    s.name = nm; s.n = n; s.miso = mi; s.st = st; s.vbf = vbf; s.abf = abf; s.fd = fd; s.exp = e;
    return s;
  endfunction

  initial begin
    seg_t segs[$];
    int   n, k;
    bit   wr_seen, strobe_now;
    logic [7:0] v;
    logic [4:0] E_VID, E_AUD, E_HUNT;

    E_VID  = {1'b0, 1'b1, 1'b1, 1'b0, TO_E};
    E_AUD  = {1'b0, 1'b1, 1'b0, 1'b1, TO_E};
    E_HUNT = {1'b0, 1'b1, 1'b0, 1'b0, TO_E};
    segs.push_back(mk("video_rand",     200, 2, 0, 0, 0, 0, E_VID));
    segs.push_back(mk("to_audio",         1, 2, 0, 1, 0, 0, E_AUD));
    segs.push_back(mk("audio_vbf_ign",    1, 2, 0, 1, 0, 0, E_AUD));
    segs.push_back(mk("fd_in_audio",      1, 2, 0, 0, 0, 1, E_AUD));
    segs.push_back(mk("audio_start_ign",  1, 2, 1, 0, 0, 0, E_AUD));
    segs.push_back(mk("audio_hold",      60, 2, 0, 0, 0, 0, E_AUD));
    segs.push_back(mk("abf_latched_fd",   1, 0, 0, 0, 1, 0, E_HUNT));
    segs.push_back(mk("hunt_start_ign",   1, 0, 1, 0, 0, 0, E_HUNT));
    segs.push_back(mk("hunt_zeros",     200, 0, 0, 0, 0, 0, E_HUNT));
    segs.push_back(mk("hdr_no_fd",      320, 1, 0, 0, 0, 0, E_VID));
    segs.push_back(mk("vbf2",             1, 2, 0, 1, 0, 0, E_AUD));
    segs.push_back(mk("abf2",             1, 2, 0, 0, 1, 0, E_HUNT));
    segs.push_back(mk("wait_hold",      100, 1, 0, 0, 0, 0, E_HUNT));
    segs.push_back(mk("fd_in_wait",       1, 0, 0, 0, 0, 1, E_HUNT));
    segs.push_back(mk("hdr_after_fd",   320, 1, 0, 0, 0, 0, E_VID));

    model_reset();
    repeat (3) @(posedge CLK_40);
    #1;
    check("rst_outs", outs(), 5'b11000);
    reset = 1'b1;
    repeat (3) cyc();
    check("idle_after_rst", outs(), 5'b11000);

    start = 1'b1; cyc(); start = 1'b0;
    repeat (100) cyc();
    check("cmd_cs_low", chip_select, 1'b0);
    #5 reset = 1'b0;
    model_reset();
    #2 check("rst_async", outs(), 5'b11000);
    @(posedge CLK_40); #1;
    repeat (2) cyc();
    reset = 1'b1;
    cyc();
    check("rst_release_idle", outs(), 5'b11000);

    start = 1'b1;
    repeat (80) cyc();
    start = 1'b0;
    check("start_cs_low", chip_select, 1'b0);
    wait_phase(2, 2200, "cmd_done");
    check("cmd_len", mosi_seen.size(), 48);
    if (mosi_seen.size() == 48)
      for (int b = 0; b < 6; b++) begin
        v = '0;
        for (int j = 0; j < 8; j++) v = {v[6:0], mosi_seen[b*8 + j]};
        check($sformatf("cmd_byte%0d", b), v, cmd_bytes[b]);
      end
    check("mosi_idle_hunt", MOSI, 1'b1);

`ifdef DATA_FSM_TIMEOUT_EN
    k = 0;
    MISO = 1'b0;
    while (chip_select == 1'b0 && k < (HDR_TO + 2) * STROBE) begin cyc(); k++; end
    if (chip_select == 1'b0) bound_fail("timeout_wait");
    check("timeout_flag", {timeout, chip_select, write_video}, 3'b110);
    start = 1'b1; cyc(); start = 1'b0;
    wait_phase(2, 2200, "cmd2_done");
`else
    n = 0; wr_seen = 1'b0;
    MISO = 1'b0;
    while (n < 200) begin
      strobe_now = (tick % STROBE == STROBE - 1);
      cyc();
      if (strobe_now) n++;
      wr_seen |= write_video | write_audio;
    end
    check("hunt_no_write", {wr_seen, chip_select}, 2'b00);
`endif

    n = 0;
    MISO = 1'b1;
    while (n < 8) begin
      strobe_now = (tick % STROBE == STROBE - 1);
      cyc();
      if (strobe_now) begin
        n++;
        if (n == 7) check("hdr7_no_video", write_video, 1'b0);
      end
    end
    check("hdr8_video", {write_video, write_audio}, 2'b10);

    foreach (segs[i]) begin
      for (int j = 0; j < segs[i].n; j++) begin
        MISO            = (segs[i].miso == 2) ? logic'($urandom_range(1, 0)) : (segs[i].miso == 1);
        start           = segs[i].st  && j == 0;
        video_bank_full = segs[i].vbf && j == 0;
        audio_bank_full = segs[i].abf && j == 0;
        frame_done      = segs[i].fd  && j == 0;
        cyc();
      end
      start = 1'b0; video_bank_full = 1'b0; audio_bank_full = 1'b0; frame_done = 1'b0;
      check(segs[i].name, outs(), segs[i].exp);
    end

    for (int c = 0; c < 20000; c++) begin
      MISO            = ($urandom % 4) != 0;
      start           = ($urandom % 200) == 0;
      video_bank_full = ($urandom % 150) == 0;
      audio_bank_full = ($urandom % 150) == 0;
      frame_done      = ($urandom % 300) == 0;
      reset           = ($urandom % 5000) != 0;
      cyc();
    end
    reset = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
